d2l_loopback: RTL and testbench
===============================

Name: d2l_loopback

Overview:
- Self-contained data-to-line (D2L) link block.
- Latches a 64-bit word on a one-cycle `out_en` pulse and serialises it onto an internal 1-bit line as a framed bitstream.
- An internal receiver deserialises the line back into `DATA_OUT` and raises `DONE`.
- Serves as a loopback/bring-up core for the serial link path: `DATA_OUT` must equal the launched `DATA_IN`.

Parameters:
- DATA_W, 64, payload width in bits (`DATA_IN`/`DATA_OUT` width).
- CLKS_PER_BIT, 1, clock cycles per serial bit period (≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  synchronous, active-high reset (asserted when 1).
- out_en  input  1  launch strobe, one-cycle pulse.
- DATA_IN  input  DATA_W  word to transmit, sampled only when `out_en` is accepted.
- DONE  output  1  transfer-complete flag (level).
- DATA_OUT  output  DATA_W  received word.

Behaviour:
- Reset (`rstn`=1 at a rising edge):
  - TX and RX FSMs go to IDLE, internal line = 1 (idle high), counters = 0.
  - `DONE`=0, `DATA_OUT`=0.
  - Reset overrides everything, including an in-flight frame; the partial frame is discarded.
- Frame format on the internal line, one bit per CLKS_PER_BIT clocks, total DATA_W+3 bits:
  - start bit (0);
  - DATA_W data bits, LSB first;
  - even-parity bit (XOR of data bits);
  - stop bit (1).
- TX FSM: IDLE → START → DATA(bit index 0..DATA_W-1) → PARITY → STOP → IDLE.
  - `out_en`=1 in IDLE at edge E0: `DATA_IN` is latched into the TX shift register, `DONE` clears to 0, and the line drives the start bit from E0.
  - `out_en` while TX is not IDLE is ignored; `DATA_IN` changes after E0 have no effect.
- RX FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - A 0 on the line in IDLE is the start bit.
  - Each bit is sampled on the last clock of its bit period and shifted into the RX register LSB first.
- Completion (stop bit sampled):
  - If the stop bit = 1 and received parity matches: `DATA_OUT` ← RX register and `DONE` ← 1 on the same edge.
  - With CLKS_PER_BIT=1, this edge is E0 + DATA_W + 2 (E66 for 64-bit): `DONE` is visible 67 cycles after the launch edge.
- On a framing or parity error, `DATA_OUT` and `DONE` are unchanged and RX returns to IDLE. This cannot occur in internal loopback but must be implemented.
- `DONE` is a level: it stays 1 until the next accepted `out_en` or reset. `DATA_OUT` holds its value until the next successful frame or reset.
- Simultaneous `out_en` and completion are impossible: TX is busy. A new `out_en` in the cycle after completion is accepted normally.
- Back-to-back transfers need no reset in between.
- No combinational path from inputs to outputs.

Test Plan:
- Reset with `rstn`=1 for 10 cycles:
  - `DONE`=0, `DATA_OUT`=0.
  - Release, no `out_en` for 200 cycles → outputs unchanged.
- Single transfer `DATA_IN`=64'h9F3A_7C21_BD84_5E62 with a one-cycle `out_en`:
  - `DONE` rises 67 cycles after the launch edge.
  - `DATA_OUT`=64'h9F3A_7C21_BD84_5E62.
- Change `DATA_IN` to 0 and pulse `out_en` mid-frame while sending 64'h14E9_A6D0_3B7C_8F51:
  - The pulse is ignored.
  - `DATA_OUT`=64'h14E9_A6D0_3B7C_8F51, exactly one completion.
- Back-to-back sends of 64'hC8D2_4F91_0A6B_E357 then 64'h0000_0000_0000_0001, no reset between:
  - `DONE` clears on the second `out_en` and rises again.
  - `DATA_OUT` matches each word in turn.
- Assert reset at cycle 30 of a frame carrying 64'hFFFF_FFFF_FFFF_FFFF:
  - `DONE`=0, `DATA_OUT`=0.
  - A subsequent send of 64'hE3F8_1A4D_9C20_6B75 completes correctly.
- Vectors from file (16+ random words, including all-zero and all-one), for each with CLKS_PER_BIT=1 and 4:
  - `DATA_OUT`==`DATA_IN`.
  - Latency is 67×CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/d2l_loopback.sv
// d2l_loopback: framed serial TX of a latched word, looped back through an internal RX deserialiser
// Frame: start(0), DATA_W bits LSB first, even parity, stop(1); CLKS_PER_BIT clocks per bit.
module d2l_loopback #(
  parameter int DATA_W       = 64,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              out_en,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              DONE,
  output logic [DATA_W-1:0] DATA_OUT
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_STOP = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  tx_state_t         tx_state_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [IW-1:0]     tx_idx_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic              tx_par_q;
  logic              line_q, line_d;
  logic              accept, tx_end;
  rx_state_t         rx_state_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [IW-1:0]     rx_idx_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic              rx_par_q, rx_par_ok_q;
  logic              rx_active, rx_sample;
  assign accept = out_en && tx_state_q == TX_IDLE;
  // STOP leaves one clock early so TX is idle on the cycle right after RX completes
  assign tx_end = tx_cnt_q == (tx_state_q == TX_STOP ? C_STOP : C_LAST);
  // line_d is the line level for the current clock; RX samples it on each bit's last clock
  always_comb begin
    line_d = tx_state_q == TX_IDLE   ? ~out_en :
             !tx_end                 ? line_q :
             tx_state_q == TX_START  ? tx_sr_q[0] :
             tx_state_q == TX_DATA   ? (tx_idx_q == I_LAST ? tx_par_q : tx_sr_q[1]) :
             1'b1;
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sr_q    <= '0;
      tx_par_q   <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      line_q <= line_d;
      if (tx_state_q == TX_IDLE) begin
        if (out_en) begin
          tx_state_q <= TX_START;
          tx_sr_q    <= DATA_IN;
          tx_par_q   <= ^DATA_IN;
          tx_cnt_q   <= '0;
        end
      end else if (!tx_end) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_idx_q   <= '0;
          end
          TX_DATA: begin
            tx_sr_q  <= tx_sr_q >> 1;
            tx_idx_q <= tx_idx_q + 1'b1;
            if (tx_idx_q == I_LAST) tx_state_q <= TX_PARITY;
          end
          TX_PARITY: tx_state_q <= CLKS_PER_BIT == 1 ? TX_IDLE : TX_STOP;
          default:   tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end
  assign rx_active = rx_state_q != RX_IDLE || !line_d || rx_cnt_q != '0;
  assign rx_sample = rx_cnt_q == C_LAST;
  always_ff @(posedge clk) begin
    if (rstn) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_sr_q     <= '0;
      rx_par_q    <= 1'b0;
      rx_par_ok_q <= 1'b0;
      DONE        <= 1'b0;
      DATA_OUT    <= '0;
    end else begin
      if (accept) DONE <= 1'b0;
      if (rx_active) rx_cnt_q <= rx_sample ? '0 : rx_cnt_q + 1'b1;
      if (rx_active && rx_sample) begin
        case (rx_state_q)
          RX_IDLE: begin
            rx_state_q <= RX_DATA;
            rx_idx_q   <= '0;
            rx_par_q   <= 1'b0;
          end
          RX_DATA: begin
            rx_sr_q  <= {line_d, rx_sr_q[DATA_W-1:1]};
            rx_par_q <= rx_par_q ^ line_d;
            rx_idx_q <= rx_idx_q + 1'b1;
            if (rx_idx_q == I_LAST) rx_state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            rx_par_ok_q <= rx_par_q == line_d;
            rx_state_q  <= RX_STOP;
          end
          RX_STOP: begin
            if (line_d && rx_par_ok_q) begin
              DATA_OUT <= rx_sr_q;
              DONE     <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_d2l_loopback.sv
// tb_d2l_loopback: scoreboard bench driving CLKS_PER_BIT=1 and =4 instances with identical stimulus
module tb_d2l_loopback;
  logic clk = 1'b0, rstn = 1'b1, out_en = 1'b0;
  logic [63:0] data_in = '0;
  logic done1, done4;
  logic [63:0] dout1, dout4;
  d2l_loopback #(.DATA_W(64), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rstn(rstn), .out_en(out_en), .DATA_IN(data_in), .DONE(done1), .DATA_OUT(dout1));
  d2l_loopback #(.DATA_W(64), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rstn(rstn), .out_en(out_en), .DATA_IN(data_in), .DONE(done4), .DATA_OUT(dout4));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [63:0] data; int at;} exp_t;
  exp_t q1[$], q4[$];
  exp_t e1, e4;
  int checks = 0, errors = 0;
  logic p1 = 1'b0, p4 = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Monitor: every DONE rising edge must match the oldest outstanding launch
  always @(negedge clk) begin
    if (done1 && !p1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected DONE: DATA_OUT %h with nothing launched", dout1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 DATA_OUT", dout1, e1.data);
        chk("dut1 DONE cycle", 64'(cyc), 64'(e1.at));
      end
    end
    if (done4 && !p4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4 unexpected DONE: DATA_OUT %h with nothing launched", dout4);
      end else begin
        e4 = q4.pop_front();
        chk("dut4 DATA_OUT", dout4, e4.data);
        chk("dut4 DONE cycle", 64'(cyc), 64'(e4.at));
      end
    end
    p1 = done1;
    p4 = done4;
  end
  // Launch edge E0 is the next posedge (cyc+1); DONE is set on edge E0 + 67*C - 1
  task automatic send(input logic [63:0] w);
    exp_t e;
    @(negedge clk);
    data_in = w;
    out_en  = 1'b1;
    e.data = w; e.at = cyc + 67;  q1.push_back(e);
    e.data = w; e.at = cyc + 268; q4.push_back(e);
    @(negedge clk);
    out_en  = 1'b0;
    data_in = ~w;
    chk("dut1 DONE cleared at launch", {63'd0, done1}, 64'd0);
    chk("dut4 DONE cleared at launch", {63'd0, done4}, 64'd0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 1000 && (q1.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q4.size() != 0) begin
      checks++; errors++;
      $display("FAIL completion timeout: pending dut1 %0d dut4 %0d, required 0", q1.size(), q4.size());
      q1.delete();
      q4.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " dut1 DONE"}, {63'd0, done1}, 64'd0);
    chk({tag, " dut1 DATA_OUT"}, dout1, 64'd0);
    chk({tag, " dut4 DONE"}, {63'd0, done4}, 64'd0);
    chk({tag, " dut4 DATA_OUT"}, dout4, 64'd0);
  endtask
  logic [63:0] vec [16] = '{
    64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF,
    64'hDEAD_BEEF_CAFE_F00D, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'h7E1F_03C8_B296_4D5A,
    64'h0F0F_F0F0_3C3C_C3C3, 64'h1357_9BDF_2468_ACE0, 64'hB4E2_9A71_C05D_36F8, 64'h0000_0001_0000_0000,
    64'h6A09_E667_F3BC_C908, 64'hBB67_AE85_84CA_A73B, 64'h3C6E_F372_FE94_F82B, 64'hA54F_F53A_5F1D_36F1};
  initial begin
    repeat (10) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b0;
    repeat (200) @(negedge clk);
    chk_zero("idle");
    send(64'h9F3A_7C21_BD84_5E62);
    wait_idle();
    send(64'h14E9_A6D0_3B7C_8F51);
    repeat (29) @(negedge clk);
    data_in = '0;
    out_en  = 1'b1;
    @(negedge clk);
    out_en  = 1'b0;
    wait_idle();
    repeat (300) @(negedge clk);
    chk("ignored pulse dut1 DATA_OUT", dout1, 64'h14E9_A6D0_3B7C_8F51);
    chk("ignored pulse dut4 DATA_OUT", dout4, 64'h14E9_A6D0_3B7C_8F51);
    send(64'hC8D2_4F91_0A6B_E357);
    wait_idle();
    send(64'h0000_0000_0000_0001);
    wait_idle();
    send(64'hFFFF_FFFF_FFFF_FFFF);
    repeat (29) @(negedge clk);
    rstn = 1'b1;
    q1.delete();
    q4.delete();
    repeat (2) @(negedge clk);
    chk_zero("mid-frame reset");
    rstn = 1'b0;
    repeat (300) @(negedge clk);
    chk_zero("after aborted frame");
    send(64'hE3F8_1A4D_9C20_6B75);
    wait_idle();
    foreach (vec[i]) begin
      send(vec[i]);
      wait_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
